rle_enc_param: RTL

- Parametrised successor to the 8-bit run-length encoder. It reads IN_W-bit words from an input-side FIFO and scans them one bit per cycle, LSB-first or MSB-first.
- Each run is written to an output-side FIFO as {bit ID, run length}.
- New over the previous generation: configurable word and count widths, and saturating run split when a run exceeds the counter range.
- The emitted word sits in a separate holding register, so scanning resumes without losing a bit. A `done` strobe marks the end-of-stream flush.

---
 rtl/rle_enc_param.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/rle_enc_param.sv
// Parametrised bit-serial run-length encoder: scans IN_W-bit words one bit per cycle and writes {bit, run} words.
// Optional run_total output counter is enabled by defining RLE_ENC_RUNCNT_EN.
`timescale 1ns/1ps

module rle_enc_param #(
    parameter int IN_W      = 8,
    parameter int CNT_W     = 23,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              recv_ready,
    input  logic              send_ready,
    input  logic              end_of_stream,
    input  logic [IN_W-1:0]   in_data,
    output logic              rd_req,
    output logic              wr_req,
    output logic [CNT_W:0]    out_data,
    output logic              done
`ifdef RLE_ENC_RUNCNT_EN
    ,
    output logic [31:0]       run_total
`endif
);

    localparam int IDX_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_W - 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(IN_W);

    typedef enum logic [2:0] {
        ST_REQ       = 3'd0,
        ST_WAIT      = 3'd1,
        ST_LOAD      = 3'd2,
        ST_SCAN      = 3'd3,
        ST_EMIT      = 3'd4,
        ST_EMIT_WAIT = 3'd5,
        ST_FLUSHED   = 3'd6
    } state_t;

    state_t            state_r, state_s;
    logic [IN_W-1:0]   shbuf_r, shbuf_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              val_r, val_s;
    logic              final_r, final_s;
    logic [CNT_W:0]    out_reg_r, out_reg_s;
    logic              rd_req_r, rd_req_s;
    logic              wr_req_r, wr_req_s;
    logic              done_r, done_s;
    logic              bit_s;
    logic              emit_s;

    function automatic logic scan_bit(input logic [IN_W-1:0] buf_v);
        return MSB_FIRST ? buf_v[IN_W-1] : buf_v[0];
    endfunction

    // Consumed bit leaves from the scanned end; zeros fill the far end.
    function automatic logic [IN_W-1:0] shift_out(input logic [IN_W-1:0] buf_v);
        return MSB_FIRST ? {buf_v[IN_W-2:0], 1'b0} : {1'b0, buf_v[IN_W-1:1]};
    endfunction

    // Next-state and next-register computation for the scan/emit sequencer.
    always_comb begin
        state_s   = state_r;
        shbuf_s   = shbuf_r;
        idx_s     = idx_r;
        cnt_s     = cnt_r;
        val_s     = val_r;
        final_s   = final_r;
        out_reg_s = out_reg_r;
        rd_req_s  = 1'b0;
        wr_req_s  = 1'b0;
        done_s    = 1'b0;
        emit_s    = 1'b0;
        bit_s     = scan_bit(shbuf_r);

        case (state_r)
            ST_REQ: begin
                if (recv_ready) begin
                    rd_req_s = 1'b1;
                    state_s  = ST_WAIT;
                end else if (end_of_stream && (cnt_r != CNT_ZERO)) begin
                    out_reg_s = {val_r, cnt_r};
                    cnt_s     = CNT_ZERO;
                    final_s   = 1'b1;
                    state_s   = ST_EMIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                shbuf_s = in_data;
                idx_s   = IDX_ZERO;
                state_s = ST_SCAN;
            end
            ST_SCAN: begin
                shbuf_s = shift_out(shbuf_r);
                idx_s   = idx_r + IDX_ONE;
                if (cnt_r == CNT_ZERO) begin
                    val_s = bit_s;
                    cnt_s = CNT_ONE;
                end else if (bit_s == val_r) begin
                    if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        // Saturated: close this word, same-valued run continues at 1.
                        out_reg_s = {val_r, cnt_r};
                        cnt_s     = CNT_ONE;
                        emit_s    = 1'b1;
                    end
                end else begin
                    out_reg_s = {val_r, cnt_r};
                    val_s     = bit_s;
                    cnt_s     = CNT_ONE;
                    emit_s    = 1'b1;
                end

                if (emit_s) begin
                    state_s = ST_EMIT;
                end else if (idx_r == IDX_LAST) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_EMIT: begin
                if (send_ready) begin
                    wr_req_s = 1'b1;
                    state_s  = ST_EMIT_WAIT;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_EMIT_WAIT: begin
                if (final_r) begin
                    state_s = ST_FLUSHED;
                end else if (idx_r == IDX_END) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_FLUSHED: begin
                done_s  = 1'b1;
                val_s   = 1'b0;
                cnt_s   = CNT_ZERO;
                final_s = 1'b0;
                state_s = ST_REQ;
            end
            default: begin
                state_s = ST_REQ;
            end
        endcase
    end

    // State and datapath registers; outputs come straight from flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_REQ;
            shbuf_r   <= {IN_W{1'b0}};
            idx_r     <= IDX_ZERO;
            cnt_r     <= CNT_ZERO;
            val_r     <= 1'b0;
            final_r   <= 1'b0;
            out_reg_r <= {(CNT_W+1){1'b0}};
            rd_req_r  <= 1'b0;
            wr_req_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            shbuf_r   <= shbuf_s;
            idx_r     <= idx_s;
            cnt_r     <= cnt_s;
            val_r     <= val_s;
            final_r   <= final_s;
            out_reg_r <= out_reg_s;
            rd_req_r  <= rd_req_s;
            wr_req_r  <= wr_req_s;
            done_r    <= done_s;
        end
    end

    assign rd_req   = rd_req_r;
    assign wr_req   = wr_req_r;
    assign out_data = out_reg_r;
    assign done     = done_r;

`ifdef RLE_ENC_RUNCNT_EN
    logic [31:0] run_total_r;

    // Counts written words per stream; cleared the cycle after done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_total_r <= 32'd0;
        end else if (done_r) begin
            run_total_r <= 32'd0;
        end else if (wr_req_r && (run_total_r != 32'hFFFF_FFFF)) begin
            run_total_r <= run_total_r + 32'd1;
        end else begin
            run_total_r <= run_total_r;
        end
    end

    assign run_total = run_total_r;
`endif

endmodule
